seq_det_sched: RTL and testbench
================================

# seq_det_sched

Scheduler that feeds the team's single-bit serial sequence detector from a word-wide source. Accepts WIDTH-bit words over a valid/ready handshake and shifts them MSB-first onto the detector's `x` input, one bit per clock. Samples the detector's Mealy output each bit cycle, builds a per-word hit map and keeps a saturating hit count. Owns the detector's reset, so software can restart detection with a single `clear` pulse.

## Interface
- `WIDTH`, 8: bits per input word; must be ≥ 2.
- `CNT_W`, 8: width of the saturating hit counter.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `clear` input 1: synchronous restart request, one-cycle pulse.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input WIDTH: word to shift out.
- `in_ready` output 1: word is accepted at an edge where `in_valid & in_ready`.
- `det_x` output 1: serial bit to the detector; driven straight from a flop.
- `det_rst` output 1: detector reset, active-high.
- `det_y` input 1: detector output; combinational in `det_x` (Mealy).
- `busy` output 1: a word is being shifted.
- `word_done` output 1: one-cycle pulse when a word is finished.
- `word_hits` output WIDTH: bit i = `det_y` sampled while `in_data[i]` was on `det_x`.
- `hit_cnt` output CNT_W: total `det_y` hits since the last clear or reset.

## Operation
- FSM states: CLR, IDLE, SHIFT.
- **Reset (async).**
  - state=CLR, `det_rst`=1, `in_ready`=0, `busy`=0, `det_x`=0.
  - `word_done`=0, `word_hits`=0, `hit_cnt`=0; shift register and bit index =0.
- **CLR.**
  - Outputs: `det_rst`=1, `in_ready`=0.
  - Next edge goes to IDLE, unless `clear`=1, in which case it stays in CLR.
- **IDLE.**
  - Outputs: `in_ready`=1, `det_x`=0.
  - The detector keeps clocking on these fill zeros; fill cycles are never sampled or counted.
  - On `in_valid`: latch `in_data`, set bit index = WIDTH-1, go to SHIFT.
- **SHIFT.**
  - Drives `det_x` = shift register MSB.
  - At each edge: `word_hits[idx]` ← `det_y`; `hit_cnt` increments if `det_y`=1; shift left; decrement idx.
  - When idx==0 (last bit):
    - `in_ready`=1.
    - If a word is accepted at that edge, stay in SHIFT with the new word, giving zero gap between words.
    - Otherwise go to IDLE.
    - `word_done` pulses in the cycle after the last sample edge.
- **`word_hits`.** Assembled in a working register and copied to the output at the last-bit edge, so it is valid with `word_done` and held until the next `word_done`.
- **`hit_cnt`.** Saturates at 2^CNT_W−1; no wrap.
- **`clear` (any state).**
  - Highest priority: next state is CLR and `hit_cnt` ←0 at that edge.
  - An in-flight word is aborted: no `word_done`, `word_hits` unchanged.
  - `in_valid` at the same edge is not accepted; `in_ready` is forced to 0 while `clear`=1.
- **`busy`.** Equals (state==SHIFT).

## Timing
- Acceptance edge E0 → `det_x` = `in_data[WIDTH-1]` in the cycle after E0.
- Bit `in_data[WIDTH-1-k]` is on `det_x` during cycle k+1 after E0, k=0..WIDTH-1.
- `det_y` is sampled at the edge ending each bit cycle. This is the same edge at which the detector advances, so the sample reflects the Mealy output for that bit.
- `word_done` and `word_hits` are valid WIDTH cycles after the cycle following E0 (latency WIDTH+1 edges from E0).
- Back-to-back throughput is one bit per clock.
- `clear` at edge C:
  - `det_rst`=1 for the cycle after C (longer if `clear` is repeated).
  - `in_ready`=1 the cycle after that.
- Reset release: `det_rst` stays 1 until the first rising edge; IDLE follows from that edge.
- Async reset asserted mid-SHIFT forces all reset values immediately, without a clock.

## Test plan
Bench detector model: `det_y` = `det_x` (echo), so expected hits are the data ones-count.

- **Reset.** `reset`=1 for 2 cycles, then released.
  - During reset: `det_rst`=1, `in_ready`=0, `det_x`=0, `hit_cnt`=0.
  - One edge after release: `in_ready`=1, `det_rst`=0.
- **Single word.** One word 8'hA5.
  - `det_x` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - Then `word_done`=1 for 1 cycle, `word_hits`=8'hA5, `hit_cnt`=4, `busy` back to 0.
- **Back-to-back.** 8'hFF then 8'h01 with `in_valid` held.
  - 16 contiguous bits on `det_x`, no zero gap between words.
  - `word_done` pulses exactly 8 cycles apart; `hit_cnt`=9.
- **Saturation.** CNT_W=4, send 8'hFF twice.
  - `hit_cnt` reads 8, then stops at 15; no wrap to 0.
- **Clear mid-word.** Pulse `clear` during the 4th bit of 8'hF0.
  - No `word_done`; `word_hits` keeps its prior value; `hit_cnt`=0.
  - `det_rst`=1 for exactly 1 cycle; `in_ready`=1 the cycle after.
  - Same test: `clear` and `in_valid` at the same edge → the word is not accepted.
- **Async reset mid-word.** Assert `reset` off-edge during the 3rd bit of 8'h3C.
  - `busy`, `det_x`, `hit_cnt` and `word_hits` go to 0 and `det_rst` to 1 before the next clock edge.

Source files
------------

// File: rtl/seq_det_sched.sv
// seq_det_sched: word-to-serial scheduler for the single-bit sequence detector.
//
// Accepts WIDTH-bit words over a valid/ready handshake and shifts each word
// MSB-first onto the detector input, one bit per clock. The detector's Mealy
// output is sampled at the end of every bit cycle. The samples build a
// per-word hit map and feed a saturating hit counter. The block also owns
// the detector reset, so a single `clear` pulse restarts detection cleanly.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active-high
//   clear      : synchronous restart request (one-cycle pulse)
//   in_valid   : in_data is valid
//   in_data    : word to serialise (WIDTH bits)
//   in_ready   : word accepted at an edge where in_valid & in_ready
//   det_x      : serial bit to the detector (flop output)
//   det_rst    : detector reset, active-high
//   det_y      : detector Mealy output (combinational in det_x)
//   busy       : a word is being shifted
//   word_done  : one-cycle pulse after the last bit of a word is sampled
//   word_hits  : per-bit hit map of the last completed word
//   hit_cnt    : saturating count of detector hits since clear/reset
module seq_det_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_y,
  output logic             busy,
  output logic             word_done,
  output logic [WIDTH-1:0] word_hits,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sh_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] word_hits_r;
  logic             word_done_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic             load_s;
  logic             shift_s;
  logic             last_s;

  // Next-state, handshake and datapath-control decode.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    last_s      = (idx_r == {IDX_W{1'b0}});
    case (state_r)
      ST_CLR: begin
        state_nxt_s = ST_IDLE;
      end
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (last_s) begin
          // Ready on the last bit so a waiting word follows with no gap.
          in_ready = 1'b1;
          if (in_valid) begin
            load_s      = 1'b1;
            state_nxt_s = ST_SHIFT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_CLR;
      end
    endcase
    // clear overrides everything: the in-flight word is aborted and nothing is accepted.
    if (clear) begin
      state_nxt_s = ST_CLR;
      in_ready    = 1'b0;
      load_s      = 1'b0;
      shift_s     = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register, bit index, hit map, done pulse and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_r        <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      work_r      <= {WIDTH{1'b0}};
      word_hits_r <= {WIDTH{1'b0}};
      word_done_r <= 1'b0;
      hit_cnt_r   <= {CNT_W{1'b0}};
    end else if (clear) begin
      // word_hits_r is deliberately kept: an aborted word never publishes.
      sh_r        <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      work_r      <= {WIDTH{1'b0}};
      word_done_r <= 1'b0;
      hit_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      word_done_r <= 1'b0;
      if (shift_s) begin
        work_r[idx_r] <= det_y;
        if (det_y && (hit_cnt_r != CNT_MAX)) begin
          hit_cnt_r <= hit_cnt_r + CNT_W'(1);
        end
        if (last_s) begin
          // Bit 0 is being sampled right now, so take it straight from det_y.
          word_hits_r <= {work_r[WIDTH-1:1], det_y};
          word_done_r <= 1'b1;
        end
      end
      if (load_s) begin
        sh_r  <= in_data;
        idx_r <= IDX_LAST;
      end else if (shift_s) begin
        // Zeros shift in, so det_x falls back to the fill value once a word ends.
        sh_r <= {sh_r[WIDTH-2:0], 1'b0};
        if (!last_s) begin
          idx_r <= idx_r - IDX_W'(1);
        end
      end
    end
  end

  assign det_x     = sh_r[WIDTH-1];
  assign det_rst   = (state_r == ST_CLR);
  assign busy      = (state_r == ST_SHIFT);
  assign word_done = word_done_r;
  assign word_hits = word_hits_r;
  assign hit_cnt   = hit_cnt_r;

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched. Two instances share the same
// stimulus: one with an 8-bit hit counter and one with a 4-bit counter
// for saturation. The detector model is an echo (det_y = det_x), so the
// hit map of a word equals the word itself.
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       a_in_ready, a_det_x, a_det_rst, a_det_y, a_busy, a_word_done;
  logic [7:0] a_word_hits, a_hit_cnt;
  logic       b_in_ready, b_det_x, b_det_rst, b_det_y, b_busy, b_word_done;
  logic [7:0] b_word_hits;
  logic [3:0] b_hit_cnt;

  assign a_det_y = a_det_x;
  assign b_det_y = b_det_x;

  seq_det_sched #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .det_x(a_det_x), .det_rst(a_det_rst), .det_y(a_det_y),
    .busy(a_busy), .word_done(a_word_done), .word_hits(a_word_hits), .hit_cnt(a_hit_cnt));

  seq_det_sched #(.WIDTH(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .det_x(b_det_x), .det_rst(b_det_rst), .det_y(b_det_y),
    .busy(b_busy), .word_done(b_word_done), .word_hits(b_word_hits), .hit_cnt(b_hit_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: the serial bit stream still owed on det_x.
  typedef struct {
    logic       b;
    logic       last;
    logic [7:0] w;
  } bit_t;

  bit_t       bq[$];
  logic       exp_rst = 1'b1;
  logic       pend = 1'b0;
  logic [7:0] pend_word = 8'h00;
  logic [7:0] last_hits = 8'h00;
  int         cnt_a = 0;
  int         cnt_b = 0;

  // Edge-level bookkeeping: acceptance, clear and reset as the spec defines them.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bq.delete();
      exp_rst   = 1'b1;
      pend      = 1'b0;
      cnt_a     = 0;
      cnt_b     = 0;
      last_hits = 8'h00;
    end else if (clear) begin
      bq.delete();
      exp_rst = 1'b1;
      pend    = 1'b0;
      cnt_a   = 0;
      cnt_b   = 0;
    end else begin
      // Ready when not restarting and no bit beyond the current one is owed.
      if (in_valid && !exp_rst && bq.size() == 0) begin
        for (int k = 7; k >= 0; k--) begin
          bit_t e;
          e.b    = in_data[k];
          e.last = (k == 0);
          e.w    = in_data;
          bq.push_back(e);
        end
      end
      exp_rst = 1'b0;
    end
  end

  // Monitor: compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    check("word_done", a_word_done, pend);
    if (pend) begin
      cnt_a = (cnt_a + $countones(pend_word) > 255) ? 255 : cnt_a + $countones(pend_word);
      cnt_b = (cnt_b + $countones(pend_word) > 15) ? 15 : cnt_b + $countones(pend_word);
      last_hits = pend_word;
      pend = 1'b0;
      check("hit_cnt_a", a_hit_cnt, cnt_a);
      check("hit_cnt_b", b_hit_cnt, cnt_b);
    end
    check("word_hits_a", a_word_hits, last_hits);
    check("word_hits_b", b_word_hits, last_hits);
    check("det_rst", a_det_rst, exp_rst);
    check("in_ready", a_in_ready, !clear && !exp_rst && bq.size() <= 1);
    check("busy", a_busy, bq.size() != 0);
    if (bq.size() != 0) begin
      bit_t e;
      e = bq.pop_front();
      check("det_x", a_det_x, e.b);
      if (e.last) begin
        pend      = 1'b1;
        pend_word = e.w;
      end
    end else begin
      check("det_x_fill", a_det_x, 1'b0);
    end
  end

  // Present a word and hold it until accepted; in_valid stays high on return.
  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_det_rst", a_det_rst, 1'b1);
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_det_x", a_det_x, 1'b0);
    check("rst_hit_cnt", a_hit_cnt, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", a_in_ready, 1'b1);
    check("rel_det_rst", a_det_rst, 1'b0);

    // Single word
    send(8'hA5);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("single_done", a_word_done, 1'b1);
    check("single_hits", a_word_hits, 8'hA5);
    check("single_cnt", a_hit_cnt, 8'd4);
    check("single_busy", a_busy, 1'b0);
    @(posedge clk); #1;
    check("single_done_pulse", a_word_done, 1'b0);

    // Back-to-back words with in_valid held
    pulse_clear();
    send(8'hFF);
    send(8'h01);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_done", a_word_done, 1'b1);
    check("b2b_cnt", a_hit_cnt, 8'd9);

    // Saturation of the 4-bit counter
    pulse_clear();
    send(8'hFF);
    send(8'hFF);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("sat_cnt_b", b_hit_cnt, 4'd15);
    check("sat_cnt_a", a_hit_cnt, 8'd16);

    // Clear during the 4th bit, with a word offered at the same edge
    send(8'hF0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    #1 check("clr_ready_forced", a_in_ready, 1'b0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_det_rst", a_det_rst, 1'b1);
    check("clr_cnt", a_hit_cnt, 8'h00);
    check("clr_hits_kept", a_word_hits, 8'hFF);
    check("clr_not_accepted", a_busy, 1'b0);
    @(posedge clk); #1;
    check("clr_det_rst_end", a_det_rst, 1'b0);
    check("clr_ready_back", a_in_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    // Async reset during the 3rd bit
    send(8'h3C);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("ar_busy", a_busy, 1'b0);
    check("ar_det_x", a_det_x, 1'b0);
    check("ar_hit_cnt", a_hit_cnt, 8'h00);
    check("ar_word_hits", a_word_hits, 8'h00);
    check("ar_det_rst", a_det_rst, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomised traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      clear    = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("drain_empty", bq.size(), 0);
    check("drain_pend", pend, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
